mem_lsu: RTL

// MEM-stage load/store unit; consumes EX results (alu_res as address/result, bypass_op2 as store data).

---
 rtl/mem_lsu.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: drives the req/gnt/rvalid data bus and registers MEM/WB outputs.
// Latency: non-memop 1 cycle to WB; memop at least 3 cycles (IDLE, REQ+gnt, WAIT+rvalid).
// Backpressure: stall_req_o holds the pipeline while an access is outstanding; optional MISALIGN_TRAP_EN.
module mem_lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  mask_i,
    input  logic        reg_write_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [31:0] alu_res_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] forward_data_mem_o,
    output logic        stall_req_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        wb_valid_o,
    output logic        wb_reg_write_o,
    output logic [4:0]  wb_rd_addr_o,
    output logic [31:0] wb_data_o,
    output logic        bus_err_o
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;

    logic        memop;
    logic        access;
    logic        trap;
    logic        complete;
    logic        timeout_hit;
    logic        req_active;
    logic        stall;
    logic        is_byte;
    logic        is_half;
    logic [1:0]  off_raw;
    logic [1:0]  off;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic        sign_bit;

    assign memop   = valid_i & (mem_read_i | mem_write_i);
    assign is_byte = (mask_i[1:0] == 2'b00);
    assign is_half = (mask_i[1:0] == 2'b01);
    assign off_raw = alu_res_i[1:0];

`ifdef MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = (is_half & off_raw[0]) | (!is_byte & !is_half & (off_raw != 2'b00));
    // Misaligned accesses are rejected in IDLE and never reach the bus.
    assign trap     = memop & misalign & (state == S_IDLE);
    assign off      = off_raw;
`else
    // Without trapping, low address bits are dropped to the natural alignment of the size.
    assign trap     = 1'b0;
    assign off      = is_byte ? off_raw : (is_half ? {off_raw[1], 1'b0} : 2'b00);
`endif

    assign access      = memop & !trap;
    assign complete    = (state == S_WAIT) & dmem_rvalid_i;
    // Timeout fires once the access has spent TIMEOUT_CYCLES full cycles in REQ+WAIT.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) & (state != S_IDLE) & (cnt == TO_VAL) & !complete;
    assign req_active  = (state == S_REQ) & !timeout_hit;
    assign stall       = !rst & access & !complete & !timeout_hit;

    assign forward_data_mem_o = alu_res_i;
    assign stall_req_o        = stall;

    // Byte enables and lane-replicated store data for the selected size.
    always_comb begin
        be    = 4'b1111;
        wdata = store_data_i;
        if (is_byte) begin
            be    = 4'b0001 << off;
            wdata = {4{store_data_i[7:0]}};
        end else if (is_half) begin
            be    = 4'b0011 << off;
            wdata = {2{store_data_i[15:0]}};
        end
    end

    // Load extraction: shift the addressed lane down, then sign- or zero-extend.
    always_comb begin
        shifted   = dmem_rdata_i >> {off, 3'b000};
        sign_bit  = 1'b0;
        load_data = shifted;
        if (is_byte) begin
            sign_bit  = ~mask_i[2] & shifted[7];
            load_data = {{24{sign_bit}}, shifted[7:0]};
        end else if (is_half) begin
            sign_bit  = ~mask_i[2] & shifted[15];
            load_data = {{16{sign_bit}}, shifted[15:0]};
        end
    end

    // Bus outputs are only driven while a request is actually presented.
    assign dmem_req_o   = req_active;
    assign dmem_we_o    = req_active & mem_write_i;
    assign dmem_addr_o  = req_active ? {alu_res_i[31:2], 2'b00} : 32'd0;
    assign dmem_be_o    = req_active ? be : 4'b0000;
    assign dmem_wdata_o = req_active ? wdata : 32'd0;

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: timeout wins over a same-cycle grant, a response wins over timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (access) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (timeout_hit) begin
                    state_nxt = S_IDLE;
                end else if (dmem_gnt_i) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (complete || timeout_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Cycle counter: zero in IDLE, counts REQ/WAIT cycles, saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst || state == S_IDLE) begin
            cnt <= '0;
        end else if (cnt != TO_VAL) begin
            cnt <= cnt + 1'b1;
        end
    end

    // MEM/WB pipeline registers: errors retire without a write, stalls insert bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_o     <= 1'b0;
            wb_reg_write_o <= 1'b0;
            wb_rd_addr_o   <= 5'd0;
            wb_data_o      <= 32'd0;
            bus_err_o      <= 1'b0;
        end else begin
            bus_err_o <= trap | timeout_hit;
            if (trap || timeout_hit) begin
                wb_valid_o     <= 1'b1;
                wb_reg_write_o <= 1'b0;
                wb_rd_addr_o   <= rd_addr_i;
                wb_data_o      <= alu_res_i;
            end else if (complete) begin
                wb_valid_o     <= 1'b1;
                wb_reg_write_o <= reg_write_i & mem_read_i;
                wb_rd_addr_o   <= rd_addr_i;
                wb_data_o      <= mem_read_i ? load_data : alu_res_i;
            end else if (stall) begin
                wb_valid_o     <= 1'b0;
                wb_reg_write_o <= 1'b0;
            end else begin
                wb_valid_o     <= valid_i;
                wb_reg_write_o <= valid_i & reg_write_i;
                wb_rd_addr_o   <= rd_addr_i;
                wb_data_o      <= alu_res_i;
            end
        end
    end

endmodule
